// File: rtl/vta_ctrl_pkg.sv
// Shared definitions for the fetch launch controller.
// Contents: FSM state enum, completion status codes, ap_ctrl bit indices,
// AXI response codes and two small helpers (response error test and the
// write-sequence successor state).
// Optional feature macro used by the controller: FETCH_LAUNCH_TIMEOUT_EN.
package vta_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_CNT    = 3'd1,
        S_WR_ADDR   = 3'd2,
        S_WR_START  = 3'd3,
        S_RD_CTRL   = 3'd4,
        S_POLL_WAIT = 3'd5,
        S_DONE      = 3'd6
    } state_e;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Any response other than OKAY is treated as a failed access.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

    // Register write order: insn_count, insns base address, then ap_start.
    function automatic state_e next_write_state(input state_e s);
        case (s)
            S_WR_CNT:  return S_WR_ADDR;
            S_WR_ADDR: return S_WR_START;
            default:   return S_RD_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/fetch_launch_ctrl_if.sv
// AXI4-Lite control-bus bundle between the launch controller (master) and
// the fetch block's CONTROL_BUS slave.
// Signals: AW (valid/ready/addr), W (valid/ready/data/strb), B (valid/ready/
// resp), AR (valid/ready/addr), R (valid/ready/data/resp).
interface fetch_launch_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_write_chan.sv
// Single AXI4-Lite write engine: raises AWVALID and WVALID together on
// start_i, drops each independently after its own handshake, then holds
// BREADY until the B handshake, which is reported on done_o.
// Ports: clk_i, rst_n_i (synchronous, active-low), start_i/addr_i/data_i
// (request, only issued while idle), AW/W/B channel signals, done_o.
module axil_write_chan #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    awvalid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    input  logic                    awready_i,
    output logic                    wvalid_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    input  logic                    wready_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic                    done_o
);
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  bready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic aw_done_s;
    logic w_done_s;

    assign aw_hs_s   = awvalid_q & awready_i;
    assign w_hs_s    = wvalid_q & wready_i;
    assign b_hs_s    = bready_q & bvalid_i;
    // Include this cycle's handshake so BREADY rises right after the later of the two.
    assign aw_done_s = aw_done_q | aw_hs_s;
    assign w_done_s  = w_done_q | w_hs_s;

    // Write-transaction tracking: request capture, per-channel completion, B wait.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (start_i) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            addr_q    <= addr_i;
            data_q    <= data_i;
        end else begin
            awvalid_q <= awvalid_q & ~aw_hs_s;
            wvalid_q  <= wvalid_q & ~w_hs_s;
            if (b_hs_s) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                bready_q  <= 1'b0;
            end else begin
                aw_done_q <= aw_done_s;
                w_done_q  <= w_done_s;
                bready_q  <= aw_done_s & w_done_s;
            end
        end
    end

    assign awvalid_o = awvalid_q;
    assign awaddr_o  = addr_q;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = data_q;
    assign wstrb_o   = {(DATA_WIDTH/8){1'b1}};
    assign bready_o  = bready_q;
    assign done_o    = b_hs_s;
endmodule

// File: rtl/fetch_launch_ctrl.sv
// Launch controller for the fetch block: per launch request it writes
// insn_count, the instruction base address and ap_start over AXI4-Lite,
// then polls ap_ctrl until ap_done and returns one status completion.
// Ports: ap_clk, ap_rst_n (synchronous, active-low); launch_valid/ready with
// launch_insn_count/launch_insns_addr; done_valid/ready with done_status
// (0 OK, 1 bus error, 2 timeout); m_axi_CONTROL_BUS (AXI4-Lite master).
// Optional macro FETCH_LAUNCH_TIMEOUT_EN: bounds polling by TIMEOUT_CYCLES.
module fetch_launch_ctrl
    import vta_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 5,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] REG_AP_CTRL    = 5'h00,
    parameter logic [ADDR_WIDTH-1:0] REG_INSN_COUNT = 5'h10,
    parameter logic [ADDR_WIDTH-1:0] REG_INSNS      = 5'h18,
    parameter int                    POLL_GAP       = 4,
    parameter int                    TIMEOUT_CYCLES = 4096
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        launch_valid,
    output logic        launch_ready,
    input  logic [31:0] launch_insn_count,
    input  logic [31:0] launch_insns_addr,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [1:0]  done_status,
    fetch_launch_ctrl_if.master m_axi_CONTROL_BUS
);
    localparam int PW = $clog2(POLL_GAP + 1);

    state_e                state_q, state_d;
    logic [1:0]            status_q, status_d;
    logic                  launch_ready_q;
    logic                  done_valid_q;
    logic [31:0]           insns_addr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [PW-1:0]         poll_cnt_q;

    logic                  launch_hs_s;
    logic                  wr_done_s;
    logic                  wr_start_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  poll_gap_end_s;
    logic                  timeout_s;
    logic                  unused_s;

    assign launch_hs_s    = launch_valid & launch_ready_q;
    assign ar_hs_s        = arvalid_q & m_axi_CONTROL_BUS.arready;
    assign r_hs_s         = rready_q & m_axi_CONTROL_BUS.rvalid;
    assign poll_gap_end_s = (poll_cnt_q == PW'(POLL_GAP - 1));

    axil_write_chan #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr (
        .clk_i     (ap_clk),
        .rst_n_i   (ap_rst_n),
        .start_i   (wr_start_s),
        .addr_i    (wr_addr_s),
        .data_i    (wr_data_s),
        .awvalid_o (m_axi_CONTROL_BUS.awvalid),
        .awaddr_o  (m_axi_CONTROL_BUS.awaddr),
        .awready_i (m_axi_CONTROL_BUS.awready),
        .wvalid_o  (m_axi_CONTROL_BUS.wvalid),
        .wdata_o   (m_axi_CONTROL_BUS.wdata),
        .wstrb_o   (m_axi_CONTROL_BUS.wstrb),
        .wready_i  (m_axi_CONTROL_BUS.wready),
        .bvalid_i  (m_axi_CONTROL_BUS.bvalid),
        .bready_o  (m_axi_CONTROL_BUS.bready),
        .done_o    (wr_done_s)
    );

`ifdef FETCH_LAUNCH_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    // Poll budget: restarts as polling begins, counts every poll and gap cycle.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            tmo_cnt_q <= 32'd0;
        end else if ((state_q == S_WR_START) && (state_d == S_RD_CTRL)) begin
            tmo_cnt_q <= 32'd0;
        end else if (((state_q == S_RD_CTRL) || (state_q == S_POLL_WAIT)) &&
                     (tmo_cnt_q != 32'hFFFF_FFFF)) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end else begin
            tmo_cnt_q <= tmo_cnt_q;
        end
    end

    assign timeout_s = (tmo_cnt_q >= 32'(TIMEOUT_CYCLES));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and completion-status selection.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (launch_hs_s) begin
                    state_d  = S_WR_CNT;
                    status_d = ST_OK;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_WR_CNT, S_WR_ADDR, S_WR_START: begin
                if (wr_done_s && resp_is_err(m_axi_CONTROL_BUS.bresp)) begin
                    state_d  = S_DONE;
                    status_d = ST_ERR;
                end else if (wr_done_s) begin
                    state_d  = next_write_state(state_q);
                end else begin
                    state_d  = state_q;
                end
            end
            S_RD_CTRL: begin
                // Timeout is only honoured once the read has fully completed.
                if (r_hs_s && resp_is_err(m_axi_CONTROL_BUS.rresp)) begin
                    state_d  = S_DONE;
                    status_d = ST_ERR;
                end else if (r_hs_s && m_axi_CONTROL_BUS.rdata[AP_DONE_BIT]) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end else if (r_hs_s && timeout_s) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else if (r_hs_s) begin
                    state_d  = S_POLL_WAIT;
                end else begin
                    state_d  = S_RD_CTRL;
                end
            end
            S_POLL_WAIT: begin
                if (timeout_s) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else if (poll_gap_end_s) begin
                    state_d  = S_RD_CTRL;
                end else begin
                    state_d  = S_POLL_WAIT;
                end
            end
            S_DONE: begin
                if (done_ready && done_valid_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                status_d = ST_OK;
            end
        endcase
    end

    // Write request issued on entry to each write state; the count comes straight
    // from the launch port because it is only needed on the IDLE->WR_CNT edge.
    always_comb begin
        wr_start_s = 1'b0;
        wr_addr_s  = '0;
        wr_data_s  = '0;
        case (state_d)
            S_WR_CNT: begin
                wr_start_s = (state_q != S_WR_CNT);
                wr_addr_s  = REG_INSN_COUNT;
                wr_data_s  = DATA_WIDTH'(launch_insn_count);
            end
            S_WR_ADDR: begin
                wr_start_s = (state_q != S_WR_ADDR);
                wr_addr_s  = REG_INSNS;
                wr_data_s  = DATA_WIDTH'(insns_addr_q);
            end
            S_WR_START: begin
                wr_start_s = (state_q != S_WR_START);
                wr_addr_s  = REG_AP_CTRL;
                wr_data_s  = DATA_WIDTH'(32'h1);
            end
            default: begin
                wr_start_s = 1'b0;
                wr_addr_s  = '0;
                wr_data_s  = '0;
            end
        endcase
    end

    // State, handshake outputs, read channel and poll-gap counter registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q        <= S_IDLE;
            status_q       <= ST_OK;
            launch_ready_q <= 1'b1;
            done_valid_q   <= 1'b0;
            insns_addr_q   <= 32'd0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            poll_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            status_q       <= status_d;
            launch_ready_q <= (state_d == S_IDLE);
            done_valid_q   <= (state_d == S_DONE);
            insns_addr_q   <= launch_hs_s ? launch_insns_addr : insns_addr_q;
            if ((state_d == S_RD_CTRL) && (state_q != S_RD_CTRL)) begin
                arvalid_q <= 1'b1;
            end else if (ar_hs_s) begin
                arvalid_q <= 1'b0;
            end else begin
                arvalid_q <= arvalid_q;
            end
            if (ar_hs_s) begin
                rready_q <= 1'b1;
            end else if (r_hs_s) begin
                rready_q <= 1'b0;
            end else begin
                rready_q <= rready_q;
            end
            if (state_q == S_POLL_WAIT) begin
                poll_cnt_q <= poll_cnt_q + PW'(1);
            end else begin
                poll_cnt_q <= '0;
            end
        end
    end

    assign launch_ready               = launch_ready_q;
    assign done_valid                 = done_valid_q;
    assign done_status                = status_q;
    assign m_axi_CONTROL_BUS.arvalid  = arvalid_q;
    assign m_axi_CONTROL_BUS.araddr   = REG_AP_CTRL;
    assign m_axi_CONTROL_BUS.rready   = rready_q;

    // Only ap_done is consumed from the polled word.
    assign unused_s = ^{m_axi_CONTROL_BUS.rdata, 32'(TIMEOUT_CYCLES)};
endmodule

// File: tb/tb_fetch_launch_ctrl.sv
module tb_fetch_launch_ctrl;
    import vta_ctrl_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int PG = 4;
`ifdef FETCH_LAUNCH_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 4096;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        launch_valid = 1'b0;
    logic        launch_ready;
    logic [31:0] cnt_in = 32'd0;
    logic [31:0] addr_in = 32'd0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [1:0]  done_status;

    always #5 ap_clk = ~ap_clk;

    fetch_launch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_launch_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_GAP(PG), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .launch_valid      (launch_valid),
        .launch_ready      (launch_ready),
        .launch_insn_count (cnt_in),
        .launch_insns_addr (addr_in),
        .done_valid        (done_valid),
        .done_ready        (done_ready),
        .done_status       (done_status),
        .m_axi_CONTROL_BUS (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] exp_wr_q[$];
    logic [1:0]  exp_done_q[$];

    // slave configuration
    int       aw_dly = 0;
    int       w_dly  = 0;
    int       done_poll = 1;
    int       poll_idx = 0;
    bit       ar_block = 1'b0;
    bit       err_en = 1'b0;
    logic [4:0] err_addr = 5'h18;
    int       ar_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // AXI4-Lite slave model
    initial begin : slave
        bit p_awv, p_wv, p_bready, p_arv, p_rready, aw_seen, w_seen;
        logic [4:0] p_awaddr, wr_addr;
        int aw_cnt, w_cnt;
        p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
        aw_seen = 0; w_seen = 0; p_awaddr = 5'h0; wr_addr = 5'h0; aw_cnt = 0; w_cnt = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
        forever begin
            @(posedge ap_clk);
            #2;
            if (!ap_rst_n) begin
                bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
                bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
                aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0; poll_idx = 0;
            end else begin
                if (bus.bvalid && p_bready) bus.bvalid = 1'b0;
                if (p_awv && bus.awready) begin aw_seen = 1; wr_addr = p_awaddr; end
                if (p_wv && bus.wready) w_seen = 1;
                if (aw_seen && w_seen) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = (err_en && wr_addr == err_addr) ? 2'b10 : 2'b00;
                    aw_seen = 0; w_seen = 0;
                end
                if (bus.rvalid && p_rready) bus.rvalid = 1'b0;
                if (p_arv && bus.arready) begin
                    poll_idx++;
                    bus.rvalid = 1'b1;
                    bus.rresp  = 2'b00;
                    bus.rdata  = (done_poll != 0 && poll_idx >= done_poll) ? 32'h2 : 32'h0;
                end
                if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin bus.awready = 1'b0; aw_cnt = 0; end
                if (bus.wvalid) begin bus.wready = (w_cnt >= w_dly); w_cnt++; end
                else begin bus.wready = 1'b0; w_cnt = 0; end
                bus.arready = bus.arvalid && !ar_block;
            end
            p_awv = bus.awvalid; p_awaddr = bus.awaddr; p_wv = bus.wvalid;
            p_bready = bus.bready; p_arv = bus.arvalid; p_rready = bus.rready;
        end
    end

    // Monitor / scoreboard: pops expectations whenever the DUT completes a transfer
    bit         aw_got = 0, w_got = 0;
    logic [4:0] mon_aw;
    logic [31:0] mon_w;
    bit         pv_aw = 0, pv_w = 0, pv_ar = 0, ph_aw = 0, ph_w = 0, ph_ar = 0;
    logic [4:0] pa_aw, pa_ar;
    logic [31:0] pd_w;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            aw_got = 0; w_got = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
        end else begin
            if (pv_aw && !ph_aw) chk("awvalid_held", {bus.awvalid, bus.awaddr}, {1'b1, pa_aw});
            if (pv_w && !ph_w)   chk("wvalid_held", {bus.wvalid, bus.wdata}, {1'b1, pd_w});
            if (pv_ar && !ph_ar) chk("arvalid_held", {bus.arvalid, bus.araddr}, {1'b1, pa_ar});
            if (bus.awvalid && bus.awready) begin mon_aw = bus.awaddr; aw_got = 1; end
            if (bus.wvalid && bus.wready) begin
                mon_w = bus.wdata; w_got = 1;
                chk("wstrb", bus.wstrb, 4'hF);
            end
            if (aw_got && w_got) begin
                if (exp_wr_q.size() == 0) chk("unexpected_write", {mon_aw, mon_w}, 37'h0);
                else chk("reg_write", {mon_aw, mon_w}, exp_wr_q.pop_front());
                aw_got = 0; w_got = 0;
            end
            if (bus.arvalid && bus.arready) begin
                ar_count++;
                chk("araddr", bus.araddr, 5'h00);
            end
            if (done_valid && done_ready) begin
                if (exp_done_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
                else chk("done_status", done_status, exp_done_q.pop_front());
            end
            pv_aw = bus.awvalid; ph_aw = bus.awvalid && bus.awready; pa_aw = bus.awaddr;
            pv_w  = bus.wvalid;  ph_w  = bus.wvalid && bus.wready;   pd_w  = bus.wdata;
            pv_ar = bus.arvalid; ph_ar = bus.arvalid && bus.arready; pa_ar = bus.araddr;
        end
    end

    task automatic push_std(input logic [31:0] c, input logic [31:0] a);
        exp_wr_q.push_back({5'h10, c});
        exp_wr_q.push_back({5'h18, a});
        exp_wr_q.push_back({5'h00, 32'h1});
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0; launch_valid = 1'b0; done_ready = 1'b0;
        tick(); tick();
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic launch(input logic [31:0] c, input logic [31:0] a);
        int n = 0;
        while (!launch_ready && n < 50) begin tick(); n++; end
        chk("launch_ready_wait", launch_ready, 1'b1);
        cnt_in = c; addr_in = a; launch_valid = 1'b1;
        tick();
        launch_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done_valid && cyc < max) begin tick(); cyc++; end
        chk("done_valid_arrives", done_valid, 1'b1);
    endtask

    task automatic accept_done();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cyc;
        int n;
        int snap;
        // reset state, sampled while reset is still applied
        tick(); tick();
        chk("rst_launch_ready", launch_ready, 1'b1);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_status", done_status, 2'd0);
        chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
        ap_rst_n = 1'b1;
        tick();

        // zero-wait slave, ap_done on third poll, completion held off 10 cycles
        aw_dly = 0; w_dly = 0; done_poll = 3; poll_idx = 0; ar_count = 0;
        push_std(32'd16, 32'h1000);
        exp_done_q.push_back(ST_OK);
        launch(32'd16, 32'h1000);
        wait_done(200, cyc);
        for (int i = 0; i < 10; i++) begin
            chk("hold_done_valid", done_valid, 1'b1);
            chk("hold_done_status", done_status, ST_OK);
            chk("hold_launch_ready", launch_ready, 1'b0);
            tick();
        end
        accept_done();
        tick();
        chk("poll_count", ar_count, 3);
        chk("idle_after_done", {launch_ready, done_valid}, 2'b10);

        // AW/W handshake orderings: W first, AW first, same cycle
        for (int k = 0; k < 3; k++) begin
            aw_dly = (k == 0) ? 2 : (k == 1) ? 0 : 1;
            w_dly  = (k == 0) ? 0 : (k == 1) ? 2 : 1;
            done_poll = 1; poll_idx = 0;
            push_std(32'd5 + k, 32'hA000 + 32'h100 * k);
            exp_done_q.push_back(ST_OK);
            launch(32'd5 + k, 32'hA000 + 32'h100 * k);
            wait_done(200, cyc);
            accept_done();
        end
        aw_dly = 0; w_dly = 0;

        // SLVERR on the insns write: no ap_start, no polling
        err_en = 1'b1; err_addr = 5'h18; ar_count = 0; poll_idx = 0;
        exp_wr_q.push_back({5'h10, 32'd9});
        exp_wr_q.push_back({5'h18, 32'h3000});
        exp_done_q.push_back(ST_ERR);
        launch(32'd9, 32'h3000);
        wait_done(200, cyc);
        accept_done();
        repeat (10) tick();
        chk("err_no_ar", ar_count, 0);
        err_en = 1'b0;

        // reset while ARVALID is stalled
        ar_block = 1'b1; done_poll = 1; poll_idx = 0;
        push_std(32'd3, 32'h4000);
        launch(32'd3, 32'h4000);
        n = 0;
        while (!bus.arvalid && n < 50) begin tick(); n++; end
        chk("stall_arvalid_seen", bus.arvalid, 1'b1);
        ap_rst_n = 1'b0;
        tick();
        chk("abort_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b000);
        chk("abort_launch_ready", launch_ready, 1'b1);
        chk("abort_done_valid", done_valid, 1'b0);
        ap_rst_n = 1'b1; ar_block = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", done_valid, 1'b0);
        // clean relaunch after the abort
        done_poll = 2; poll_idx = 0; ar_count = 0;
        push_std(32'd21, 32'h5000);
        exp_done_q.push_back(ST_OK);
        launch(32'd21, 32'h5000);
        wait_done(200, cyc);
        accept_done();
        tick();
        chk("relaunch_polls", ar_count, 2);

        // ap_done never set
        done_poll = 0; poll_idx = 0; ar_count = 0;
        push_std(32'd7, 32'h2000);
`ifdef FETCH_LAUNCH_TIMEOUT_EN
        exp_done_q.push_back(ST_TIMEOUT);
        launch(32'd7, 32'h2000);
        n = 0;
        while (!bus.arvalid && n < 50) begin tick(); n++; end
        chk("first_poll_seen", bus.arvalid, 1'b1);
        wait_done(200, cyc);
        chk("timeout_in_budget", (cyc <= TMO + PG + 2), 1'b1);
        accept_done();
`else
        launch(32'd7, 32'h2000);
        repeat (1000) tick();
        chk("still_polling_no_done", done_valid, 1'b0);
        chk("still_polling_ar", (ar_count > 100), 1'b1);
        do_reset();
`endif

        repeat (3) tick();
        chk("writes_drained", exp_wr_q.size(), 0);
        chk("dones_drained", exp_done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
